biquad8_zero_fir_coeff_seq: RTL and testbench

//  Sequencer that loads a new (b, a) coefficient pair into the zero-FIR stage of a biquad.

---
 rtl/biquad_ctrl_pkg.sv | 28 ++
 rtl/biquad_wait_cnt.sv | 37 +++
 rtl/biquad8_zero_fir_coeff_seq.sv | 177 +++++++++++++++++
 tb/tb_biquad8_zero_fir_coeff_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/biquad_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : biquad_ctrl_pkg
//  Description : Shared types and default constants for the biquad control
//                path. Holds the coefficient-sequencer state encoding and the
//                FIR pipeline delays used as parameter defaults.
//  Contents    : coeff_seq_state_t, COEFF_BITS_DEF, FIR_BYP_DLY,
//                FIR_SETTLE_DLY
//  Revision    : 1.0 - initial release
// ============================================================================
package biquad_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BYP_ON  = 3'd1,
        WR_B    = 3'd2,
        WR_A    = 3'd3,
        UPD     = 3'd4,
        SETTLE  = 3'd5,
        BYP_OFF = 3'd6
    } coeff_seq_state_t;

    localparam int COEFF_BITS_DEF = 18;  // Q4.14, matches FIR coeff_dat_i
    localparam int FIR_BYP_DLY    = 3;   // bypass_o change -> FIR output bypassed
    localparam int FIR_SETTLE_DLY = 4;   // coeff_update -> new coeffs at FIR output

endpackage
`default_nettype wire

// File: rtl/biquad_wait_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : biquad_wait_cnt
//  Description : Loadable down-counter that saturates at zero. A wait state
//                loads (delay-1) on entry and leaves when o_zero is seen.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                i_load        - load i_load_val this clock
//                i_load_val    - reload value
//                o_zero        - counter currently at zero
//  Revision    : 1.0 - initial release
// ============================================================================
module biquad_wait_cnt #(
    parameter int CNT_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [CNT_BITS-1:0] i_load_val,
    output logic                o_zero
);

    logic [CNT_BITS-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/biquad8_zero_fir_coeff_seq.sv
`default_nettype none
// ============================================================================
//  Module      : biquad8_zero_fir_coeff_seq
//  Description : Loads one (b, a) coefficient pair per valid/ready handshake
//                into the zero-FIR serial coefficient port (b, a, update) and
//                drives the FIR bypass input.
//                Build option BIQUAD_COEFF_SEQ_BYPASS_EN: wraps every swap in
//                a bypass window and keeps the FIR bypassed until the first
//                pair has been loaded. Without it the bypass output is only
//                the registered host request.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                req_valid_i/req_ready_o/req_b_i/req_a_i - pair handshake
//                bypass_req_i    - host bypass request (level)
//                coeff_dat_o/coeff_wr_o/coeff_update_o - FIR coeff port
//                bypass_o        - FIR bypass
//                loaded_o        - a pair has completed since reset
//                done_o          - sequence complete pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module biquad8_zero_fir_coeff_seq
    import biquad_ctrl_pkg::*;
#(
    parameter int COEFF_BITS = COEFF_BITS_DEF,
    parameter int BYP_DLY    = FIR_BYP_DLY,
    parameter int SETTLE_DLY = FIR_SETTLE_DLY,
    parameter int CNT_BITS   = 4     // 2**CNT_BITS must exceed both delays
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [COEFF_BITS-1:0] req_b_i,
    input  logic [COEFF_BITS-1:0] req_a_i,
    input  logic                  bypass_req_i,
    output logic [COEFF_BITS-1:0] coeff_dat_o,
    output logic                  coeff_wr_o,
    output logic                  coeff_update_o,
    output logic                  bypass_o,
    output logic                  loaded_o,
    output logic                  done_o
);

    // A wait state of N clocks loads N-1; delays of 0 and 1 both give one clock.
    localparam logic [CNT_BITS-1:0] c_BYP_LOAD    = CNT_BITS'((BYP_DLY    > 0) ? BYP_DLY    - 1 : 0);
    localparam logic [CNT_BITS-1:0] c_SETTLE_LOAD = CNT_BITS'((SETTLE_DLY > 0) ? SETTLE_DLY - 1 : 0);

    coeff_seq_state_t        r_state;
    coeff_seq_state_t        w_next;
    logic [COEFF_BITS-1:0]   r_b;
    logic [COEFF_BITS-1:0]   r_a;
    logic [COEFF_BITS-1:0]   r_coeff_dat;
    logic [COEFF_BITS-1:0]   w_b_src;
    logic                    r_coeff_wr;
    logic                    r_coeff_upd;
    logic                    r_bypass;
    logic                    r_loaded;
    logic                    r_done;
    logic                    w_accept;
    logic                    w_seq_end;
    logic                    w_cnt_load;
    logic [CNT_BITS-1:0]     w_cnt_load_val;
    logic                    w_cnt_zero;

    assign req_ready_o = (r_state == IDLE) && !rst;
    assign w_accept    = req_valid_i && (r_state == IDLE);

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef BIQUAD_COEFF_SEQ_BYPASS_EN
                    w_next = BYP_ON;
`else
                    w_next = WR_B;
`endif
                end
            end
            BYP_ON:  if (w_cnt_zero) w_next = WR_B;
            WR_B:    w_next = WR_A;
            WR_A:    w_next = UPD;
            UPD:     w_next = SETTLE;
            SETTLE: begin
                if (w_cnt_zero) begin
`ifdef BIQUAD_COEFF_SEQ_BYPASS_EN
                    w_next = BYP_OFF;
`else
                    w_next = IDLE;
`endif
                end
            end
            BYP_OFF: if (w_cnt_zero) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_seq_end      = (r_state != IDLE) && (w_next == IDLE);
    assign w_cnt_load     = (w_next != r_state) &&
                            ((w_next == BYP_ON) || (w_next == SETTLE) || (w_next == BYP_OFF));
    assign w_cnt_load_val = (w_next == SETTLE) ? c_SETTLE_LOAD : c_BYP_LOAD;
    // Outputs are registered against the next state, so WR_B entered straight
    // from IDLE must take b from the port rather than the latch being written.
    assign w_b_src        = (r_state == IDLE) ? req_b_i : r_b;

    biquad_wait_cnt #(
        .CNT_BITS (CNT_BITS)
    ) u_wait_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .o_zero     (w_cnt_zero)
    );

`ifdef BIQUAD_COEFF_SEQ_BYPASS_EN
    // Set once a coefficient set has fully settled in the FIR; until then the
    // FIR output is meaningless and must stay bypassed. It flips on BYP_OFF
    // entry so the unbypass propagates before done_o is raised.
    logic r_armed;
    logic w_seq_byp_next;

    assign w_seq_byp_next = (w_next == BYP_ON) || (w_next == WR_B) || (w_next == WR_A) ||
                            (w_next == UPD)    || (w_next == SETTLE);
`endif

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_b         <= '0;
            r_a         <= '0;
            r_coeff_dat <= '0;
            r_coeff_wr  <= 1'b0;
            r_coeff_upd <= 1'b0;
            r_loaded    <= 1'b0;
            r_done      <= 1'b0;
`ifdef BIQUAD_COEFF_SEQ_BYPASS_EN
            r_armed     <= 1'b0;
            r_bypass    <= 1'b1;
`else
            r_bypass    <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_b <= req_b_i;
                r_a <= req_a_i;
            end
            if (w_next == WR_B) begin
                r_coeff_dat <= w_b_src;
            end else if (w_next == WR_A) begin
                r_coeff_dat <= r_a;
            end
            r_coeff_wr  <= (w_next == WR_B) || (w_next == WR_A);
            r_coeff_upd <= (w_next == UPD);
            r_done      <= w_seq_end;
            r_loaded    <= r_loaded | w_seq_end;
`ifdef BIQUAD_COEFF_SEQ_BYPASS_EN
            r_armed     <= r_armed | (w_next == BYP_OFF);
            r_bypass    <= bypass_req_i | w_seq_byp_next |
                           ~(r_armed | (w_next == BYP_OFF));
`else
            r_bypass    <= bypass_req_i;
`endif
        end
    end

    assign coeff_dat_o    = r_coeff_dat;
    assign coeff_wr_o     = r_coeff_wr;
    assign coeff_update_o = r_coeff_upd;
    assign bypass_o       = r_bypass;
    assign loaded_o       = r_loaded;
    assign done_o         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_biquad8_zero_fir_coeff_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_biquad8_zero_fir_coeff_seq
//  Description : Directed self-checking bench for biquad8_zero_fir_coeff_seq.
//                Models the FIR coefficient registers (b/a shadow on write,
//                active on update). Follows BIQUAD_COEFF_SEQ_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_biquad8_zero_fir_coeff_seq;

    localparam int CB = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [CB-1:0] req_b_i = '0;
    logic [CB-1:0] req_a_i = '0;
    logic          bypass_req_i = 1'b0;
    logic [CB-1:0] coeff_dat_o;
    logic          coeff_wr_o;
    logic          coeff_update_o;
    logic          bypass_o;
    logic          loaded_o;
    logic          done_o;

    int n_total = 0;
    int n_pass  = 0;

    // FIR coefficient register model
    logic [CB-1:0] sh_b = '0, sh_a = '0, act_b = '0, act_a = '0;
    logic          wr_phase = 1'b0;
    int            n_wr = 0, n_upd = 0;

    biquad8_zero_fir_coeff_seq dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_b_i        (req_b_i),
        .req_a_i        (req_a_i),
        .bypass_req_i   (bypass_req_i),
        .coeff_dat_o    (coeff_dat_o),
        .coeff_wr_o     (coeff_wr_o),
        .coeff_update_o (coeff_update_o),
        .bypass_o       (bypass_o),
        .loaded_o       (loaded_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (coeff_wr_o) begin
            if (!wr_phase) sh_b <= coeff_dat_o;
            else           sh_a <= coeff_dat_o;
            wr_phase <= ~wr_phase;
            n_wr     <= n_wr + 1;
        end
        if (coeff_update_o) begin
            act_b <= sh_b;
            act_a <= sh_a;
            n_upd <= n_upd + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    localparam logic [CB-1:0] B1 = 18'h04000, A1 = 18'h3F000;
    localparam logic [CB-1:0] B2 = 18'h01234, A2 = 18'h2ABCD;
    localparam logic [CB-1:0] B3 = 18'h15555, A3 = 18'h0AAAA;
    localparam logic [CB-1:0] B4 = 18'h00F0F, A4 = 18'h3C3C3;

    initial begin
        // ---------------- reset state
        step(2);
        check("rst_ready", req_ready_o, 0);
        check("rst_wr", coeff_wr_o, 0);
        check("rst_upd", coeff_update_o, 0);
        check("rst_done", done_o, 0);
        check("rst_loaded", loaded_o, 0);
        check("rst_dat", coeff_dat_o, 0);
        rst = 1'b0;
        step(1);
        check("idle_ready", req_ready_o, 1);
`ifdef BIQUAD_COEFF_SEQ_BYPASS_EN
        check("rst_bypass", bypass_o, 1);
        step(20);
        check("idle_no_wr", n_wr, 0);
        check("idle_no_upd", n_upd, 0);
        check("idle_bypass", bypass_o, 1);

        // ---------------- first load, clk0 = handshake clock
        req_valid_i = 1'b1; req_b_i = B1; req_a_i = A1;
        step(1);                                   // clk1
        req_valid_i = 1'b0; req_b_i = B3; req_a_i = A3;
        check("en_ready_busy", req_ready_o, 0);
        check("en_byp_on", bypass_o, 1);
        step(2);                                   // clk3
        check("en_no_wr_clk3", coeff_wr_o, 0);
        step(1);                                   // clk4
        check("en_wr_b", coeff_wr_o, 1);
        check("en_dat_b", coeff_dat_o, B1);
        step(1);                                   // clk5
        check("en_dat_a", coeff_dat_o, A1);
        step(1);                                   // clk6
        check("en_upd", coeff_update_o, 1);
        step(4);                                   // clk10
        check("en_byp_clk10", bypass_o, 1);
        step(1);                                   // clk11
        check("en_byp_off_clk11", bypass_o, 0);
        check("en_no_done_clk11", done_o, 0);
        step(3);                                   // clk14
        check("en_done", done_o, 1);
        check("en_loaded", loaded_o, 1);
        check("en_act_b", act_b, B1);
        check("en_act_a", act_a, A1);
        step(1);
        check("en_done_pulse", done_o, 0);

        // ---------------- host bypass held through a load
        bypass_req_i = 1'b1;
        step(1);
        check("en_host_byp", bypass_o, 1);
        req_valid_i = 1'b1; req_b_i = B2; req_a_i = A2;
        step(1);                                   // clk1
        req_valid_i = 1'b0;
        step(10);                                  // clk11
        check("en_host_byp_clk11", bypass_o, 1);
        step(3);                                   // clk14
        check("en_host_done", done_o, 1);
        bypass_req_i = 1'b0;
        step(1);
        check("en_host_release", bypass_o, 0);
        check("en_wr_count", n_wr, 4);

        // ---------------- reset during SETTLE
        req_valid_i = 1'b1; req_b_i = B3; req_a_i = A3;
        step(1);
        req_valid_i = 1'b0;
        step(7);                                   // clk8, SETTLE
        rst = 1'b1;
        #1;
        check("en_mid_rst_loaded", loaded_o, 0);
        check("en_mid_rst_bypass", bypass_o, 1);
        check("en_mid_rst_ready", req_ready_o, 0);
        step(1);
        rst = 1'b0;
        step(1);
        req_valid_i = 1'b1; req_b_i = B4; req_a_i = A4;
        step(1);
        req_valid_i = 1'b0;
        step(13);                                  // clk14
        check("en_after_rst_done", done_o, 1);
        check("en_after_rst_act_b", act_b, B4);
        check("en_after_rst_act_a", act_a, A4);
`else
        check("rst_bypass", bypass_o, 0);
        step(20);
        check("idle_no_wr", n_wr, 0);
        check("idle_no_upd", n_upd, 0);

        // ---------------- first load; second pair queued while busy
        req_valid_i = 1'b1; req_b_i = B1; req_a_i = A1;   // clk0
        step(1);                                   // clk1
        req_b_i = B2; req_a_i = A2;                // valid held for next pair
        check("ready_busy", req_ready_o, 0);
        check("wr_b", coeff_wr_o, 1);
        check("dat_b", coeff_dat_o, B1);
        step(1);                                   // clk2
        check("wr_a", coeff_wr_o, 1);
        check("dat_a_latched", coeff_dat_o, A1);
        step(1);                                   // clk3
        check("upd", coeff_update_o, 1);
        check("wr_off_upd", coeff_wr_o, 0);
        check("dat_hold", coeff_dat_o, A1);
        step(4);                                   // clk7
        check("no_done_clk7", done_o, 0);
        check("loaded_clk7", loaded_o, 0);
        step(1);                                   // clk8
        check("done", done_o, 1);
        check("loaded", loaded_o, 1);
        check("ready_done", req_ready_o, 1);
        check("act_b", act_b, B1);
        check("act_a", act_a, A1);
        check("pulses_one_pair", n_wr + 16 * n_upd, 2 + 16);

        // ---------------- second pair accepted on done clock, host bypass
        step(1);                                   // clk9
        req_valid_i = 1'b0; req_b_i = B3; req_a_i = A3;
        bypass_req_i = 1'b1;
        check("q_wr_b", coeff_dat_o, B2);
        check("q_done_pulse", done_o, 0);
        step(1);                                   // clk10
        check("host_byp", bypass_o, 1);
        check("q_dat_a", coeff_dat_o, A2);
        step(1);                                   // clk11
        check("q_upd", coeff_update_o, 1);
        bypass_req_i = 1'b0;
        step(1);                                   // clk12
        check("host_byp_release", bypass_o, 0);
        step(4);                                   // clk16
        check("q_done", done_o, 1);
        check("q_act_b", act_b, B2);
        check("q_act_a", act_a, A2);
        check("pulses_two_pairs", n_wr + 16 * n_upd, 4 + 32);

        // ---------------- reset during SETTLE
        step(2);
        req_valid_i = 1'b1; req_b_i = B3; req_a_i = A3;
        step(1);
        req_valid_i = 1'b0;
        step(4);                                   // clk5, SETTLE
        rst = 1'b1;
        #1;
        check("mid_rst_loaded", loaded_o, 0);
        check("mid_rst_ready", req_ready_o, 0);
        check("mid_rst_dat", coeff_dat_o, 0);
        step(1);
        rst = 1'b0;
        step(1);
        req_valid_i = 1'b1; req_b_i = B4; req_a_i = A4;
        step(1);                                   // clk1
        req_valid_i = 1'b0;
        check("after_rst_dat_b", coeff_dat_o, B4);
        step(7);                                   // clk8
        check("after_rst_done", done_o, 1);
        check("after_rst_loaded", loaded_o, 1);
        check("after_rst_act_b", act_b, B4);
        check("after_rst_act_a", act_a, A4);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
